// File: rtl/neuron_datapath.sv
// Single-neuron datapath: loads inputs and weights from the controller's IN/BUFF phases,
// then runs a sequential MAC with bias, ReLU, shift and saturation during OUT.
module neuron_datapath #(
   parameter int                 N_INPUTS = 4,
   parameter logic signed [7:0]  BIAS     = 8'sd0,
   parameter int                 SHIFT    = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] state,
   input  logic [7:0] data_in,
   input  logic       data_valid,
   output logic [7:0] result,
   output logic       result_valid,
   output logic       finished,
   output logic       busy
);

   localparam int IW = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
   localparam logic [IW-1:0] LAST = IW'(N_INPUTS - 1);

   typedef enum logic [1:0] {MAC_IDLE, MAC_ACC, MAC_DONE} mac_state_t;

   mac_state_t mac_state, mac_next;

   logic [1:0]        prev_state;
   logic [IW-1:0]     ptr;
   logic [IW-1:0]     idx;
   logic signed [7:0] x [N_INPUTS];
   logic signed [7:0] w [N_INPUTS];
   logic signed [19:0] acc;

   logic          phase_change;
   logic          in_out;
   logic          start;
   logic          wr_en;
   logic [IW-1:0] wr_idx;
   logic [IW-1:0] ptr_next;
   logic [15:0]   prod;
   logic [19:0]   prod_ext;
   logic [20:0]   biased;
   logic [20:0]   shifted;
   logic [7:0]    sat_val;

   assign phase_change = (state != prev_state);
   assign in_out       = (state == 2'b10);
   assign start        = phase_change && in_out;
   assign wr_en        = data_valid && (state == 2'b00 || state == 2'b01);
   assign wr_idx       = phase_change ? '0 : ptr;
   assign ptr_next     = (wr_idx == LAST) ? '0 : wr_idx + 1'b1;

   // Low 16 bits of the sign-extended product equal the signed 8x8 product.
   assign prod     = {{8{x[idx][7]}}, x[idx]} * {{8{w[idx][7]}}, w[idx]};
   assign prod_ext = {{4{prod[15]}}, prod};

   assign biased  = {acc[19], acc} + {{13{BIAS[7]}}, BIAS};
   assign shifted = $unsigned($signed(biased) >>> SHIFT);
   assign sat_val = biased[20] ? 8'd0 : ((|shifted[20:8]) ? 8'hFF : shifted[7:0]);

   assign busy = (mac_state != MAC_IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) mac_state <= MAC_IDLE;
      else       mac_state <= mac_next;
   end

   // Leaving OUT at any point abandons the MAC; entering OUT always restarts it.
   always_comb begin
      mac_next = mac_state;
      case (mac_state)
         MAC_IDLE: if (start) mac_next = MAC_ACC;
         MAC_ACC: begin
            if (!in_out)           mac_next = MAC_IDLE;
            else if (idx == LAST)  mac_next = MAC_DONE;
         end
         MAC_DONE: mac_next = MAC_IDLE;
         default:  mac_next = MAC_IDLE;
      endcase
      if (start) mac_next = MAC_ACC;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prev_state   <= 2'b00;
         ptr          <= '0;
         idx          <= '0;
         acc          <= '0;
         result       <= '0;
         result_valid <= 1'b0;
         finished     <= 1'b0;
         for (int i = 0; i < N_INPUTS; i++) begin
            x[i] <= '0;
            w[i] <= '0;
         end
      end else begin
         prev_state   <= state;
         result_valid <= 1'b0;

         if (wr_en) begin
            if (state == 2'b00) x[wr_idx] <= data_in;
            else                w[wr_idx] <= data_in;
            ptr <= ptr_next;
         end else if (phase_change) begin
            ptr <= '0;
         end

         if (!in_out) finished <= 1'b0;

         if (start) begin
            acc <= '0;
            idx <= '0;
         end else if (mac_state == MAC_ACC && in_out) begin
            acc <= acc + $signed(prod_ext);
            idx <= idx + 1'b1;
         end else if (mac_state == MAC_DONE && in_out) begin
            result       <= sat_val;
            result_valid <= 1'b1;
            finished     <= 1'b1;
         end
      end
   end

endmodule
